fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front end sitting directly upstream of the L1 instruction cache.
- Owns the PC and issues one word-read request at a time to the cache over a hold-until-ready handshake.
- Buffers returned instructions with their PCs in a small FIFO for the decode stage.
- Handles branch/exception redirects, including redirects that arrive while a cache miss refill is in flight.

Parameters:
- ADDR_WIDTH, 32, PC and cache address width.
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- FIFO_DEPTH, 4, instruction buffer entries; must be a power of 2, at least 2.
- PTR_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- cache_read_en  out  1  request valid to the instruction cache.
- cache_addr  out  ADDR_WIDTH  word address of the request; bits [1:0] are always 0.
- cache_ready  in  1  cache has valid data for cache_addr this cycle.
- cache_data  in  32  instruction word; valid only when cache_read_en && cache_ready.
- redirect_en  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
- dec_valid  out  1  FIFO head is valid.
- dec_inst  out  32  FIFO head instruction.
- dec_pc  out  ADDR_WIDTH  FIFO head PC.
- dec_ready  in  1  decode consumes the head this cycle when dec_valid is high.

Behaviour:

Reset:
- While rst is high: pc = RESET_PC, FIFO empty (count = 0, pointers = 0), state = FETCH, saved_target = 0.
- Outputs during reset: cache_read_en = 0, dec_valid = 0, dec_inst = 0, dec_pc = 0.
- Reset asserted mid-miss abandons the request; the cache is reset by the same signal.

Handshake:
- A request, once asserted, is held with cache_addr stable until cache_ready is seen. The cache uses the address across its whole refill.
- Accept = cache_read_en && cache_ready.
- Hit latency is 0 cycles: an instruction is pushed into the FIFO on the accept edge and is visible at dec_* on the next cycle.

State machine (2 states, registered):

FETCH:
- cache_read_en = !full; cache_addr = pc.
- Accept with no redirect: push {pc, cache_data}; pc <= pc + 4, wrapping modulo 2^ADDR_WIDTH.
- redirect_en with no outstanding miss (cache_read_en = 0, or cache_ready = 1): FIFO cleared; any word accepted this cycle is discarded; pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; stay in FETCH.
- redirect_en while cache_read_en = 1 and cache_ready = 0 (miss in flight): FIFO cleared; saved_target <= aligned redirect_pc; go to KILL; pc is not changed.

KILL:
- cache_read_en = 1; cache_addr = pc (the old address); nothing is pushed.
- On cache_ready: returned word is dropped; pc <= saved_target; go to FETCH. The first new request issues the following cycle.
- A new redirect_en in KILL overwrites saved_target and clears the FIFO. If it coincides with cache_ready, the newest target is used.

FIFO:
- Circular buffer with read/write pointers wrapping at FIFO_DEPTH, plus a count of width PTR_WIDTH+1.
- full = (count == FIFO_DEPTH); empty = (count == 0); dec_valid = !empty.
- Pop = dec_valid && dec_ready. Simultaneous push and pop leaves count unchanged.
- When full, no push is possible because cache_read_en = 0. A pop while full re-enables requests on the next cycle; push never bypasses in the same cycle.
- redirect_en has priority over push and pop: count <= 0, pointers <= 0, and a same-cycle pop is discarded with no effect.
- dec_inst and dec_pc are driven directly from the head entry (combinational read).

Test Plan:
- Reset release, cache hits every cycle, dec_ready = 1 -> requests at BFC00000, BFC00004, BFC00008; dec_pc follows one cycle later; one instruction per cycle.
- dec_ready = 0 with hits -> exactly 4 pushes; cache_read_en drops with count = 4. Raise dec_ready for 1 cycle -> one pop, cache_read_en = 1 on the next cycle, addr BFC00010.
- Miss: cache_ready low for 20 cycles at BFC00004 -> cache_addr held at BFC00004 for all 21 cycles; single push on the ready cycle; no duplicate.
- redirect_en with redirect_pc = 8000_1003 while 3 entries are buffered and no miss -> dec_valid = 0 next cycle; next request at 80001000.
- redirect_en to 80002000 during a miss at BFC00040, then a second redirect to 80003000 before cache_ready -> addr stays BFC00040 until ready; returned word not pushed; next request at 80003000.
- PC wrap: redirect to FFFFFFFC, hit -> next request at 00000000.
- rst pulse mid-miss -> cache_read_en = 0 and dec_valid = 0 immediately (asynchronous); after release, fetch restarts at BFC00000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end ahead of the L1 instruction cache.
// Owns the PC, issues one word read at a time (held until cache_ready),
// buffers returned words with their PCs in a small FIFO for decode, and
// handles redirects, including ones that land while a miss refill is active.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cache_read_en/cache_addr  request to the I-cache (held until ready)
//   cache_ready/cache_data    cache response; accept = read_en && ready
//   redirect_en/redirect_pc   one-cycle restart request and its target
//   dec_valid/dec_inst/dec_pc FIFO head presented to decode
//   dec_ready                 decode consumes the head when dec_valid
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter int unsigned           PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  cache_read_en,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_ready,
    input  logic [31:0]           cache_data,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  dec_valid,
    output logic [31:0]           dec_inst,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    input  logic                  dec_ready
);

    typedef enum logic {
        FETCH = 1'b0,
        KILL  = 1'b1
    } state_t;

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(FIFO_DEPTH);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic [ADDR_WIDTH-1:0] saved_target, saved_nxt;
    logic [ADDR_WIDTH-1:0] target;
    logic                  push, pop, full, empty;
    logic [PTR_WIDTH:0]    count;
    logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [31:0]           inst_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic                  unused_low_bits;

    // Low two target bits are discarded by word alignment.
    assign target          = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];

    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);
    assign dec_valid  = !empty;
    // A redirect flushes the FIFO, so a same-cycle pop has no effect.
    assign pop        = dec_valid && dec_ready && !redirect_en;
    assign cache_addr = pc;

    // Storage is not reset; gating on empty keeps dec_* at zero in reset.
    assign dec_inst = empty ? '0 : inst_mem[rd_ptr];
    assign dec_pc   = empty ? '0 : pc_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            saved_target <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            saved_target <= saved_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        saved_nxt     = saved_target;
        cache_read_en = 1'b0;
        push          = 1'b0;
        case (state)
            FETCH: begin
                cache_read_en = !full && !rst;
                if (redirect_en) begin
                    // A refill in flight must complete on the old address
                    // before the new target can be requested.
                    if (cache_read_en && !cache_ready) begin
                        state_nxt = KILL;
                        saved_nxt = target;
                    end else begin
                        pc_nxt = target;
                    end
                end else if (cache_read_en && cache_ready) begin
                    push   = 1'b1;
                    pc_nxt = pc + ADDR_WIDTH'(4);
                end
            end
            KILL: begin
                cache_read_en = !rst;
                if (redirect_en) begin
                    saved_nxt = target;
                end
                if (cache_ready) begin
                    pc_nxt    = redirect_en ? target : saved_target;
                    state_nxt = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect_en) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= cache_data;
            pc_mem[wr_ptr]   <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// The cache model returns cache_addr ^ KEY as the instruction word so each
// buffered instruction can be tied back to the PC it was fetched from.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_read_en;
    logic [31:0] cache_addr;
    logic        cache_ready;
    logic [31:0] cache_data;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'hBFC00000),
        .FIFO_DEPTH (4),
        .PTR_WIDTH  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cache_read_en (cache_read_en),
        .cache_addr    (cache_addr),
        .cache_ready   (cache_ready),
        .cache_data    (cache_data),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .dec_valid     (dec_valid),
        .dec_inst      (dec_inst),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready)
    );

    always #5 clk = ~clk;

    assign cache_data = cache_addr ^ KEY;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        cache_ready = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_read_en", 32'(cache_read_en), 32'd0);
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_inst", dec_inst, 32'd0);
        chk("rst_pc", dec_pc, 32'd0);
        chk("rst_addr", cache_addr, 32'hBFC00000);

        // Streaming hits, one instruction per cycle
        cache_ready = 1'b1;
        dec_ready   = 1'b1;
        rst         = 1'b0;
        #1;
        chk("s0_read_en", 32'(cache_read_en), 32'd1);
        chk("s0_addr", cache_addr, 32'hBFC00000);
        chk("s0_valid", 32'(dec_valid), 32'd0);
        tick();
        chk("s1_addr", cache_addr, 32'hBFC00004);
        chk("s1_valid", 32'(dec_valid), 32'd1);
        chk("s1_pc", dec_pc, 32'hBFC00000);
        chk("s1_inst", dec_inst, 32'hBFC00000 ^ KEY);
        tick();
        chk("s2_addr", cache_addr, 32'hBFC00008);
        chk("s2_pc", dec_pc, 32'hBFC00004);
        chk("s2_inst", dec_inst, 32'hBFC00004 ^ KEY);

        // Fill to full, then a single pop
        dec_ready = 1'b0;
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("full_read_en", 32'(cache_read_en), 32'd0);
        chk("full_addr", cache_addr, 32'hBFC00010);
        chk("full_head", dec_pc, 32'hBFC00000);
        tick();
        chk("full_hold", 32'(cache_read_en), 32'd0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("pop_read_en", 32'(cache_read_en), 32'd1);
        chk("pop_addr", cache_addr, 32'hBFC00010);
        chk("pop_head", dec_pc, 32'hBFC00004);
        tick();
        chk("refull_read_en", 32'(cache_read_en), 32'd0);
        chk("refull_head", dec_pc, 32'hBFC00004);

        // Long miss at BFC00004
        do_reset();
        rst       = 1'b0;
        dec_ready = 1'b1;
        tick();
        cache_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("miss_addr", cache_addr, 32'hBFC00004);
            chk("miss_read_en", 32'(cache_read_en), 32'd1);
            tick();
        end
        chk("miss_empty", 32'(dec_valid), 32'd0);
        cache_ready = 1'b1;
        chk("miss_last_addr", cache_addr, 32'hBFC00004);
        tick();
        cache_ready = 1'b0;
        chk("miss_push_valid", 32'(dec_valid), 32'd1);
        chk("miss_push_pc", dec_pc, 32'hBFC00004);
        chk("miss_push_inst", dec_inst, 32'hBFC00004 ^ KEY);
        chk("miss_next_addr", cache_addr, 32'hBFC00008);
        tick();
        chk("miss_no_dup", 32'(dec_valid), 32'd0);

        // Redirect with 3 buffered entries, no miss
        dec_ready   = 1'b0;
        cache_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("buf3_head", dec_pc, 32'hBFC00008);
        redirect_en = 1'b1;
        redirect_pc = 32'h80001003;
        tick();
        redirect_en = 1'b0;
        chk("redir_flush", 32'(dec_valid), 32'd0);
        chk("redir_addr", cache_addr, 32'h80001000);
        chk("redir_read_en", 32'(cache_read_en), 32'd1);
        tick();
        chk("redir_push_pc", dec_pc, 32'h80001000);
        chk("redir_push_inst", dec_inst, 32'h80001000 ^ KEY);

        // Redirects during a miss at BFC00040
        redirect_en = 1'b1;
        redirect_pc = 32'hBFC00040;
        tick();
        redirect_en = 1'b0;
        cache_ready = 1'b0;
        tick();
        tick();
        chk("kill_pre_addr", cache_addr, 32'hBFC00040);
        redirect_en = 1'b1;
        redirect_pc = 32'h80002000;
        tick();
        redirect_en = 1'b0;
        chk("kill_addr0", cache_addr, 32'hBFC00040);
        chk("kill_read_en", 32'(cache_read_en), 32'd1);
        chk("kill_valid", 32'(dec_valid), 32'd0);
        tick();
        tick();
        chk("kill_addr1", cache_addr, 32'hBFC00040);
        redirect_en = 1'b1;
        redirect_pc = 32'h80003000;
        tick();
        redirect_en = 1'b0;
        chk("kill_addr2", cache_addr, 32'hBFC00040);
        tick();
        cache_ready = 1'b1;
        chk("kill_addr3", cache_addr, 32'hBFC00040);
        tick();
        chk("kill_dropped", 32'(dec_valid), 32'd0);
        chk("kill_new_addr", cache_addr, 32'h80003000);
        chk("kill_new_read_en", 32'(cache_read_en), 32'd1);
        dec_ready = 1'b1;
        tick();
        chk("kill_new_push", dec_pc, 32'h80003000);

        // PC wrap
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        tick();
        redirect_en = 1'b0;
        chk("wrap_addr0", cache_addr, 32'hFFFFFFFC);
        chk("wrap_flush", 32'(dec_valid), 32'd0);
        tick();
        chk("wrap_addr1", cache_addr, 32'h00000000);
        chk("wrap_head", dec_pc, 32'hFFFFFFFC);

        // Asynchronous reset mid-miss
        dec_ready   = 1'b0;
        cache_ready = 1'b0;
        tick();
        chk("pre_rst_read_en", 32'(cache_read_en), 32'd1);
        chk("pre_rst_valid", 32'(dec_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_read_en", 32'(cache_read_en), 32'd0);
        chk("arst_valid", 32'(dec_valid), 32'd0);
        chk("arst_inst", dec_inst, 32'd0);
        chk("arst_pc", dec_pc, 32'd0);
        tick();
        rst         = 1'b0;
        cache_ready = 1'b1;
        #1;
        chk("restart_addr", cache_addr, 32'hBFC00000);
        chk("restart_read_en", 32'(cache_read_en), 32'd1);
        tick();
        chk("restart_push", dec_pc, 32'hBFC00000);
        chk("restart_next", cache_addr, 32'hBFC00004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
